tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
Registered 1-to-4 time-division demultiplexer. It is the receive end of the 4-channel 2-bit select/enable mux path. It takes a serial stream of W-bit beats, each tagged with valid and frame-sync, and distributes each 4-beat frame into four channel registers. The four outputs update atomically once per complete frame. It sits between the serial link and the downstream consumers of channels A-D.

Parameters:
W, 2, width of each beat and each channel output

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; beats are ignored while low
din  input  W  beat data
din_valid  input  1  din carries a beat this cycle
din_sync  input  1  qualifies the beat as slot 0 (frame start)
a  output  W  channel 0 (slot 0) data, registered
b  output  W  channel 1 (slot 1) data, registered
c  output  W  channel 2 (slot 2) data, registered
d  output  W  channel 3 (slot 3) data, registered
sel  output  2  slot index expected for the next beat
frame_valid  output  1  one-cycle pulse: a..d were just updated
frame_err  output  1  one-cycle pulse: framing violation

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=HUNT, slot=0, stage[0..2]=0, a=b=c=d=0, sel=0, frame_valid=0, frame_err=0. Assertion mid-frame discards the partial frame immediately.
- A beat is accepted only when en=1 and din_valid=1 at a rising edge. Otherwise state, slot, stage and outputs hold, and the pulses are 0.
- HUNT state:
  - Accepted beat with sync=0: discarded, no error.
  - Accepted beat with sync=1: stage[0]=din, slot=1, go to RUN.
- RUN state, accepted beat at slot k:
  - k=0, sync=1: stage[0]=din, slot=1.
  - k=0, sync=0: missing sync. Beat discarded, frame_err=1 next cycle, go to HUNT, slot=0.
  - k=1..2, sync=0: stage[k]=din, slot=k+1.
  - k=3, sync=0: a=stage[0], b=stage[1], c=stage[2], d=din, all on the same edge. frame_valid=1 for exactly the next cycle; slot=0.
  - k=1..3, sync=1: early sync. Partial frame discarded, a..d unchanged, frame_err=1 next cycle. The beat is taken as a new slot 0: stage[0]=din, slot=1, stay in RUN.
- Latency: a..d and frame_valid become visible one cycle after the edge sampling the 4th beat. Back-to-back frames at one beat per cycle sustain one frame_valid per 4 cycles.
- frame_valid and frame_err are never high in the same cycle.
- sel = slot, always (0 in HUNT).
- Deasserting en mid-frame pauses the frame; it does not abort it.
- a..d hold their value until the next complete frame.

Optional Feature:
TDM_PARITY_EN
- Defined:
  - Adds input din_par (1 bit): even parity over din.
  - An accepted beat whose parity mismatches is treated as a framing violation: frame_err pulse, partial frame discarded, go to HUNT.
  - Adds output par_err (1 bit), a one-cycle pulse coincident with that frame_err.
- Undefined: no din_par/par_err ports, no parity check.

Decomposition:
- Package tdm_pkg:
  - NCH=4, SLOT_W=2.
  - State enum {HUNT, RUN}.
  - Slot constants SLOT_A..SLOT_D.
- No sub-module. Control is a 2-state FSM plus a 2-bit counter, kept inline. The parity check is a single XOR reduction under the macro.

Test Plan:
- Normal frame, W=2: beats (sync,din) = (1,00),(0,01),(0,10),(0,11), en=1 throughout → a=00, b=01, c=10, d=11; frame_valid high for 1 cycle after beat 4; sel sequence 1,2,3,0.
- Early sync: after a good frame, send (1,11),(0,10),(1,01),(0,00),(0,11),(0,10) → frame_err pulse after beat 3; a..d unchanged until the new frame completes as a=01, b=00, c=11, d=10.
- Missing sync: in RUN at slot 0, send (0,11) → frame_err pulse, sel=0, HUNT. Subsequent non-sync beats are ignored with no further errors; the next sync restarts the frame.
- Enable gating: start a frame, drop en for 5 cycles with din_valid=1 and random din, then raise en and finish the frame → stalled beats ignored; the frame completes with the intended data and a single frame_valid.
- Reset mid-frame: after 2 beats, pulse rst_n low asynchronously between edges → all outputs 0 immediately. A fresh 4-beat frame then produces correct outputs.
- With TDM_PARITY_EN: beat 2 sent with a wrong din_par → par_err and frame_err pulse together; a..d unchanged; frame_valid does not fire for that frame.

Source files
------------

// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [SLOT_W-1:0] SLOT_A = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_B = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_C = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / 4-channel-out bundle for tdm_demux4.
// Optional TDM_PARITY_EN adds din_par and par_err.
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int W = 2
);
  logic              en;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              din_sync;
`ifdef TDM_PARITY_EN
  logic              din_par;
  logic              par_err;
`endif
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [W-1:0]      c;
  logic [W-1:0]      d;
  logic [SLOT_W-1:0] sel;
  logic              frame_valid;
  logic              frame_err;

  modport master (
`ifdef TDM_PARITY_EN
    output din_par,
    input  par_err,
`endif
    output en, din, din_valid, din_sync,
    input  a, b, c, d, sel, frame_valid, frame_err
  );

  modport slave (
`ifdef TDM_PARITY_EN
    input  din_par,
    output par_err,
`endif
    input  en, din, din_valid, din_sync,
    output a, b, c, d, sel, frame_valid, frame_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 TDM demultiplexer; outputs update atomically per frame.
// Build option TDM_PARITY_EN enables even-parity checking of each beat.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [W-1:0]      stage [NCH-1];
  logic [W-1:0]      a_q, b_q, c_q, d_q;
  logic              fv_q, fe_q;
  logic              take;
  logic              par_bad;

  assign take = bus.en & bus.din_valid;

`ifdef TDM_PARITY_EN
  logic pe_q;
  assign par_bad     = ^{bus.din, bus.din_par};
  assign bus.par_err = pe_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= SLOT_A;
      stage[0] <= '0;
      stage[1] <= '0;
      stage[2] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
`ifdef TDM_PARITY_EN
      pe_q     <= 1'b0;
`endif
    end else begin
      fv_q <= 1'b0;
      fe_q <= 1'b0;
`ifdef TDM_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (take) begin
        if (par_bad) begin
          // A corrupt beat poisons the whole frame: resynchronise from scratch.
          fe_q  <= 1'b1;
`ifdef TDM_PARITY_EN
          pe_q  <= 1'b1;
`endif
          state <= HUNT;
          slot  <= SLOT_A;
        end else if (bus.din_sync) begin
          // Sync always starts a new frame; mid-frame it also flags the lost partial.
          stage[0] <= bus.din;
          slot     <= SLOT_B;
          state    <= RUN;
          if (state == RUN && slot != SLOT_A) fe_q <= 1'b1;
        end else if (state == RUN) begin
          case (slot)
            SLOT_A: begin
              fe_q  <= 1'b1;
              state <= HUNT;
              slot  <= SLOT_A;
            end
            SLOT_B: begin
              stage[1] <= bus.din;
              slot     <= SLOT_C;
            end
            SLOT_C: begin
              stage[2] <= bus.din;
              slot     <= SLOT_D;
            end
            default: begin
              a_q  <= stage[0];
              b_q  <= stage[1];
              c_q  <= stage[2];
              d_q  <= bus.din;
              fv_q <= 1'b1;
              slot <= SLOT_A;
            end
          endcase
        end
      end
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.d           = d_q;
  assign bus.sel         = slot;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;

endmodule
